// File: rtl/relu_requant_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// relu_requant_buffer_if : result-in / sample-out valid-ready bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface relu_requant_buffer_if #(
    parameter int IN_WIDTH  = 28,
    parameter int OUT_WIDTH = 14
);
    logic                        input_valid;
    logic                        input_ready;
    logic signed [IN_WIDTH-1:0]  input_data;
    logic                        output_valid;
    logic                        output_ready;
    logic        [OUT_WIDTH-1:0] output_data;
    logic                        output_last;

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_data, output_last
    );

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_data, output_last
    );
endinterface
`default_nettype wire

// File: rtl/relu_requant_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// relu_requant_buffer : ReLU + round/shift/saturate requantizer with output FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module relu_requant_buffer #(
    parameter int IN_WIDTH  = 28,
    parameter int OUT_WIDTH = 14,
    parameter int SHIFT     = 7,
    parameter int DEPTH     = 4,
    parameter int ROWS      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    relu_requant_buffer_if.slave  bus,
    output logic [7:0]            sat_count
);
    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [c_aw:0]          c_full     = (c_aw+1)'(DEPTH);
    localparam logic [c_row_w-1:0]     c_last_row = c_row_w'(ROWS - 1);
    localparam logic signed [IN_WIDTH:0] c_round  = (IN_WIDTH+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [IN_WIDTH:0] c_max    = (IN_WIDTH+1)'((1 <<< (OUT_WIDTH - 1)) - 1);

    logic [OUT_WIDTH:0]   r_mem [DEPTH];
    logic [c_aw-1:0]      r_wrptr;
    logic [c_aw-1:0]      r_rdptr;
    logic [c_aw:0]        r_count;
    logic [c_row_w-1:0]   r_row;
    logic [7:0]           r_sat;

    logic                        w_push;
    logic                        w_pop;
    logic                        w_neg;
    logic                        w_sat;
    logic                        w_last;
    logic signed [IN_WIDTH:0]    w_ext;
    logic signed [IN_WIDTH:0]    w_shifted;
    logic [OUT_WIDTH-1:0]        w_out;
    logic [OUT_WIDTH:0]          w_head;

    // One extra bit of headroom so adding the rounding constant never wraps.
    always_comb begin
        w_neg     = bus.input_data[IN_WIDTH-1];
        w_ext     = $signed({bus.input_data[IN_WIDTH-1], bus.input_data}) + c_round;
        w_shifted = w_ext >>> SHIFT;
        w_sat     = !w_neg && (w_shifted > c_max);
        if (w_neg) begin
            w_out = '0;
        end else if (w_sat) begin
            w_out = c_max[OUT_WIDTH-1:0];
        end else begin
            w_out = w_shifted[OUT_WIDTH-1:0];
        end
    end

    assign bus.input_ready  = reset && (r_count != c_full);
    assign bus.output_valid = (r_count != '0);
    assign w_push           = bus.input_valid && bus.input_ready;
    assign w_pop            = bus.output_valid && bus.output_ready;
    assign w_last           = (r_row == c_last_row);
    assign w_head           = r_mem[r_rdptr];
    assign bus.output_data  = bus.output_valid ? w_head[OUT_WIDTH-1:0] : '0;
    assign bus.output_last  = bus.output_valid && w_head[OUT_WIDTH];
    assign sat_count        = r_sat;

    // Storage is not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrptr] <= {w_last, w_out};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
            r_count <= '0;
            r_row   <= '0;
            r_sat   <= '0;
        end else begin
            if (w_push) begin
                r_wrptr <= r_wrptr + 1'b1;
                r_row   <= w_last ? '0 : r_row + 1'b1;
                if (w_sat && (r_sat != 8'hFF)) begin
                    r_sat <= r_sat + 1'b1;
                end
            end
            if (w_pop) begin
                r_rdptr <= r_rdptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_relu_requant_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_relu_requant_buffer : randomized scoreboard bench for relu_requant_buffer
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_relu_requant_buffer;
    localparam int IN_W  = 28;
    localparam int OUT_W = 14;
    localparam int SHIFT = 7;
    localparam int ROWS  = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sat_count;

    always #5 clk = ~clk;

    relu_requant_buffer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

    relu_requant_buffer #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(SHIFT), .DEPTH(4), .ROWS(ROWS)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .sat_count (sat_count)
    );

    int              n_checks = 0;
    int              n_pass   = 0;
    logic [OUT_W:0]  exp_q[$];
    int              model_row = 0;
    int              model_sat = 0;
    int              rdy_mode  = 0;
    logic            rdy_hold  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: ReLU, round-half-up divide by 2^SHIFT, clamp to max positive.
    task automatic model_push(input logic signed [IN_W-1:0] d);
        longint x, r, maxv;
        bit     sat;
        x    = longint'(d);
        maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
        sat  = 1'b0;
        if (x < 0) r = 0;
        else begin
            r = (x + (longint'(1) <<< (SHIFT - 1))) / (longint'(1) <<< SHIFT);
            if (r > maxv) begin r = maxv; sat = 1'b1; end
        end
        exp_q.push_back({(model_row == ROWS - 1), r[OUT_W-1:0]});
        model_row = (model_row + 1) % ROWS;
        if (sat && model_sat < 255) model_sat++;
    endtask

    function automatic logic signed [IN_W-1:0] rand28();
        logic [31:0] u;
        u = $urandom;
        case ($urandom_range(0, 3))
            0: return IN_W'($urandom_range(0, 1 << 21));
            1: return -IN_W'($urandom_range(1, 1 << 27));
            2: return u[IN_W-1:0];
            default: return IN_W'(1048512 + $urandom_range(0, 127) - 64);
        endcase
    endfunction

    // Downstream ready generator, changes just after the rising edge.
    initial begin
        bus.output_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.output_ready = rdy_hold;
                1:       bus.output_ready = ~bus.output_ready;
                default: bus.output_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted output.
    logic           prev_stall = 1'b0;
    logic [OUT_W:0] prev_val   = '0;
    initial begin
        logic [OUT_W:0] e;
        forever begin
            @(negedge clk);
            if (reset && bus.output_valid) begin
                if (prev_stall)
                    check("hold_stable", {bus.output_last, bus.output_data}, prev_val);
                if (bus.output_ready) begin
                    if (exp_q.size() == 0) check("unexpected_output", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("out_data", bus.output_data, e[OUT_W-1:0]);
                        check("out_last", bus.output_last, e[OUT_W]);
                    end
                end
            end
            prev_stall = reset && bus.output_valid && !bus.output_ready;
            prev_val   = {bus.output_last, bus.output_data};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    task automatic push(input logic signed [IN_W-1:0] d, input bit jitter);
        int t = 0;
        @(negedge clk);
        bus.input_valid = 1'b1;
        bus.input_data  = d;
        while (!bus.input_ready && t < 500) begin
            @(negedge clk);
            t++;
            if (jitter) begin d = rand28(); bus.input_data = d; end
        end
        if (!bus.input_ready) check("push_timeout", 0, 1);
        else model_push(d);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.input_valid = 1'b0;
        bus.input_data  = rand28();
    endtask

    task automatic drain();
        int t = 0;
        rdy_mode = 0;
        rdy_hold = 1'b1;
        while ((exp_q.size() != 0 || bus.output_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk);
        #2;
        reset           = 1'b0;
        bus.input_valid = 1'b0;
        exp_q.delete();
        model_row = 0;
        model_sat = 0;
        repeat (cycles) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        bus.input_valid = 1'b0;
        bus.input_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.output_valid, 0);
        check("rst_out_data", bus.output_data, 0);
        check("rst_in_ready", bus.input_ready, 0);
        check("rst_sat", sat_count, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", bus.input_ready, 1);

        // Basic transform and last flag
        rdy_hold = 1'b1;
        push(28'sd1000, 0);
        push(-28'sd5000, 0);
        push(28'sd63, 0);
        idle();
        drain();

        // Saturation
        push(28'sh7FFFFFF, 0);
        push(28'sd1048512, 0);
        idle();
        drain();
        check("sat_two", sat_count, model_sat);

        // Fill to full with downstream stalled
        rdy_hold = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 4; i++) push(IN_W'(i << 7), 0);
        @(negedge clk);
        bus.input_valid = 1'b1;
        bus.input_data  = IN_W'(5 << 7);
        check("full_in_ready", bus.input_ready, 0);
        check("full_out_valid", bus.output_valid, 1);
        check("full_head", bus.output_data, 1);
        rdy_hold = 1'b1;
        push(IN_W'(5 << 7), 0);
        idle();
        drain();

        // Toggling ready stream from a fresh row counter
        apply_reset(2);
        rdy_mode = 1;
        for (int i = 0; i < 7; i++) push(IN_W'($urandom_range(0, 1 << 20)), 0);
        idle();
        drain();

        // Reset mid-stream discards buffered entries and restarts rows
        rdy_hold = 1'b0;
        repeat (2) @(negedge clk);
        push(28'sd5000, 0);
        push(28'sd6000, 0);
        idle();
        apply_reset(2);
        @(negedge clk);
        check("mid_rst_valid", bus.output_valid, 0);
        check("mid_rst_ready", bus.input_ready, 1);
        @(negedge clk);
        check("mid_rst_valid2", bus.output_valid, 0);
        rdy_hold = 1'b1;
        for (int i = 0; i < 3; i++) push(IN_W'($urandom_range(0, 1 << 22)), 0);
        idle();
        drain();

        // Saturation counter sticks at 255
        for (int i = 0; i < 260; i++) push(28'sh7FFFFFF, 0);
        idle();
        drain();
        check("sat_stick", sat_count, model_sat);
        check("sat_stick_255", sat_count, 255);

        // Randomized traffic with random backpressure and stall jitter
        apply_reset(1);
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            push(rand28(), 1);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        drain();
        check("sat_random", sat_count, model_sat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
